// File: rtl/ip_pkg.sv
// rtl/ip_pkg.sv - shared IPv4 header constants, checksum types and fold helper
package ip_pkg;

  localparam int IP_HDR_MAXLEN  = 60;
  localparam int IP_CSUM_HW_IDX = 5;

  typedef enum logic {
    CSUM_VERIFY   = 1'b0,
    CSUM_GENERATE = 1'b1
  } csum_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_FOLD1,
    ST_FOLD2,
    ST_EMIT
  } csum_state_t;

  function automatic logic [15:0] ip_csum_fold(input logic [23:0] acc);
    logic [16:0] s;
    s = {1'b0, acc[15:0]} + {9'd0, acc[23:16]};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_csum_fold.sv
// rtl/ip_csum_fold.sv - two-stage end-around-carry fold and complement of a 24-bit sum
module ip_csum_fold
  import ip_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [23:0] acc_i,
  input  logic        gen_i,
  input  logic        err_i,
  output logic        valid_o,
  output logic [15:0] csum_o,
  output logic        ok_o,
  output logic        err_o
);

  logic        v1_q, v2_q;
  logic [16:0] s_q;
  logic        gen1_q, err1_q;
  logic [15:0] csum_q;
  logic        ok_q, err2_q;
  logic [15:0] f;

  // s_q[16] set implies s_q[15:0] <= 0x00FE, so this add cannot carry out
  assign f = s_q[15:0] + {15'd0, s_q[16]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      s_q    <= '0;
      gen1_q <= 1'b0;
      err1_q <= 1'b0;
      csum_q <= '0;
      ok_q   <= 1'b0;
      err2_q <= 1'b0;
    end else begin
      v1_q <= valid_i;
      v2_q <= v1_q;
      if (valid_i) begin
        s_q    <= {1'b0, acc_i[15:0]} + {9'd0, acc_i[23:16]};
        gen1_q <= gen_i;
        err1_q <= err_i;
      end
      if (v1_q) begin
        csum_q <= ~f;
        ok_q   <= (gen1_q | (f == 16'hFFFF)) & ~err1_q;
        err2_q <= err1_q;
      end
    end
  end

  assign valid_o = v2_q;
  assign csum_o  = csum_q;
  assign ok_o    = ok_q;
  assign err_o   = err2_q;

endmodule

// File: rtl/ip_csum_engine.sv
// rtl/ip_csum_engine.sv - buffers one IPv4 header, verifies or generates its checksum, re-emits it
module ip_csum_engine
  import ip_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int MAX_IHL = 15
) (
  input  logic                  clk156,
  input  logic                  sys_rst,
  input  logic                  mode,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_sof,
  input  logic [16*LANES-1:0]   s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eof,
  output logic [16*LANES-1:0]   m_data,
  output logic                  res_valid,
  output logic                  res_ok,
  output logic                  res_ihl_err,
  output logic [15:0]           res_csum
);

  localparam int W          = 16 * LANES;
  localparam int DEPTH      = (MAX_IHL * 2 + LANES - 1) / LANES;
  localparam int PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PATCH_WORD = IP_CSUM_HW_IDX / LANES;
  localparam int PATCH_LANE = IP_CSUM_HW_IDX % LANES;

  csum_state_t   state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, last_q, last_d, wr_slot;
  logic [23:0]   acc_q, acc_d;
  logic [7:0]    hwt_q, hwt_d;
  logic          gen_q, gen_d, err_q, err_d, wr_en;
  logic [W-1:0]  buf_q [DEPTH];

  logic [3:0]    ihl_new;
  logic          err_new, gen_new;
  logic [7:0]    hwt_new, base;
  logic [PW-1:0] last_new;

  // Halfwords past the header end pass through unsummed; the check field counts as 0 when generating
  function automatic logic [23:0] word_sum(input logic [W-1:0] data, input logic [7:0] first,
                                           input logic [7:0] hwt, input logic gen);
    logic [23:0] s;
    logic [7:0]  idx;
    s = '0;
    for (int j = 0; j < LANES; j++) begin
      idx = first + 8'(j);
      if ((idx < hwt) && !(gen && (idx == 8'(IP_CSUM_HW_IDX))))
        s = s + {8'd0, data[W-1-16*j -: 16]};
    end
    return s;
  endfunction

  assign ihl_new  = s_data[W-5:W-8];
  assign err_new  = (ihl_new < 4'd5) || (int'(ihl_new) > MAX_IHL);
  assign gen_new  = (csum_mode_t'(mode) == CSUM_GENERATE);
  assign hwt_new  = err_new ? 8'd10 : {3'd0, ihl_new, 1'b0};
  assign last_new = PW'((hwt_new + 8'(LANES - 1)) / 8'(LANES) - 8'd1);
  assign base     = 8'(wptr_q) * 8'(LANES);

  assign s_ready  = (state_q == ST_IDLE) || (state_q == ST_COLLECT);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    last_d  = last_q;
    acc_d   = acc_q;
    hwt_d   = hwt_q;
    gen_d   = gen_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_slot = wptr_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (s_valid && s_sof) begin
          // a new start-of-header also abandons any header being collected
          gen_d   = gen_new;
          err_d   = err_new;
          hwt_d   = hwt_new;
          last_d  = last_new;
          acc_d   = word_sum(s_data, 8'd0, hwt_new, gen_new);
          wr_en   = 1'b1;
          wr_slot = '0;
          wptr_d  = PW'(1);
          rptr_d  = '0;
          state_d = (hwt_new <= 8'(LANES)) ? ST_FOLD1 : ST_COLLECT;
        end else if (s_valid && (state_q == ST_COLLECT)) begin
          acc_d  = acc_q + word_sum(s_data, base, hwt_q, gen_q);
          wr_en  = 1'b1;
          wptr_d = wptr_q + PW'(1);
          if ((base + 8'(LANES)) >= hwt_q) state_d = ST_FOLD1;
        end
      end
      ST_FOLD1: state_d = ST_FOLD2;
      ST_FOLD2: state_d = ST_EMIT;
      ST_EMIT: begin
        if (m_ready) begin
          if (rptr_q == last_q) state_d = ST_IDLE;
          else                  rptr_d  = rptr_q + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      last_q  <= '0;
      acc_q   <= '0;
      hwt_q   <= '0;
      gen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      hwt_q   <= hwt_d;
      gen_q   <= gen_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk156) begin
    if (wr_en) buf_q[wr_slot] <= s_data;
  end

  ip_csum_fold u_fold (
    .clk_i   (clk156),
    .rst_i   (sys_rst),
    .valid_i (state_q == ST_FOLD1),
    .acc_i   (acc_q),
    .gen_i   (gen_q),
    .err_i   (err_q),
    .valid_o (res_valid),
    .csum_o  (res_csum),
    .ok_o    (res_ok),
    .err_o   (res_ihl_err)
  );

  assign m_valid = (state_q == ST_EMIT);
  assign m_sof   = m_valid && (rptr_q == '0);
  assign m_eof   = m_valid && (rptr_q == last_q);

  always_comb begin
    m_data = '0;
    if (state_q == ST_EMIT) begin
      m_data = buf_q[rptr_q];
      if (gen_q && !err_q && (rptr_q == PW'(PATCH_WORD)))
        m_data[W-1-16*PATCH_LANE -: 16] = res_csum;
    end
  end

endmodule

// File: tb/tb_ip_csum_engine.sv
// tb/tb_ip_csum_engine.sv - scoreboard bench for ip_csum_engine
module tb_ip_csum_engine;
  import ip_pkg::*;

  localparam int LANES   = 4;
  localparam int MAX_IHL = 15;
  localparam int W       = 16 * LANES;

  typedef struct packed {
    logic [W-1:0] data;
    logic         sof;
    logic         eof;
  } exp_word_t;

  typedef struct packed {
    logic [15:0] csum;
    logic        ok;
    logic        err;
  } exp_res_t;

  localparam logic [15:0] T1 [12] = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011, 16'hb861,
                                      16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7, 16'hdead, 16'hbeef};
  localparam logic [15:0] T3 [12] = '{16'h4600, 16'h0078, 16'h0000, 16'h4000, 16'h4011, 16'h0000,
                                      16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7, 16'h9404, 16'h0000};

  logic         clk156 = 1'b0;
  logic         sys_rst = 1'b1;
  logic         mode = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_sof = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         m_ready = 1'b1;
  logic         s_ready, m_valid, m_sof, m_eof, res_valid, res_ok, res_ihl_err;
  logic [W-1:0] m_data;
  logic [15:0]  res_csum;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  exp_word_t    exp_word_q[$];
  exp_res_t     exp_res_q[$];
  exp_word_t    mw;
  exp_res_t     mr;
  logic [15:0]  hdr [32];
  int           hdr_n;
  logic [W-1:0] cap_words [16];
  int           cap_n = 0;
  logic [15:0]  last_csum = '0;
  logic         last_ok = 1'b0;
  logic         last_err = 1'b0;
  logic [W-1:0] d1;

  ip_csum_engine #(.LANES(LANES), .MAX_IHL(MAX_IHL)) dut (
    .clk156      (clk156),
    .sys_rst     (sys_rst),
    .mode        (mode),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_sof       (s_sof),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_sof       (m_sof),
    .m_eof       (m_eof),
    .m_data      (m_data),
    .res_valid   (res_valid),
    .res_ok      (res_ok),
    .res_ihl_err (res_ihl_err),
    .res_csum    (res_csum)
  );

  always #3 clk156 = ~clk156;
  always @(posedge clk156) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int k);
    logic [W-1:0] d;
    for (int j = 0; j < LANES; j++) d[W-1-16*j -: 16] = hdr[k*LANES+j];
    return d;
  endfunction

  task automatic load12(input logic [15:0] src [12]);
    for (int i = 0; i < 12; i++) hdr[i] = src[i];
    hdr_n = 12;
  endtask

  task automatic push_expect(input logic md);
    logic [3:0]   ihl;
    logic         err;
    int           hwt;
    logic [31:0]  acc;
    logic [15:0]  f, csum;
    exp_res_t     r;
    exp_word_t    e;
    logic [W-1:0] d;
    int           nw, idx;
    ihl = hdr[0][11:8];
    err = (ihl < 4'd5) || (int'(ihl) > MAX_IHL);
    hwt = err ? 10 : int'(ihl) * 2;
    acc = '0;
    for (int i = 0; i < hwt; i++)
      if (!(md && i == IP_CSUM_HW_IDX)) acc = acc + {16'd0, hdr[i]};
    f = ip_csum_fold(acc[23:0]);
    csum = ~f;
    r.csum = csum;
    r.ok   = (md ? 1'b1 : (f == 16'hFFFF)) && !err;
    r.err  = err;
    exp_res_q.push_back(r);
    nw = hdr_n / LANES;
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < LANES; j++) begin
        idx = k * LANES + j;
        d[W-1-16*j -: 16] = (md && !err && idx == IP_CSUM_HW_IDX) ? csum : hdr[idx];
      end
      e.data = d;
      e.sof  = (k == 0);
      e.eof  = (k == nw - 1);
      exp_word_q.push_back(e);
    end
  endtask

  task automatic send_hdr(input logic md);
    int nw, tmo;
    nw = hdr_n / LANES;
    push_expect(md);
    cap_n = 0;
    for (int k = 0; k < nw; k++) begin
      @(negedge clk156);
      s_valid = 1'b1;
      s_sof   = (k == 0);
      mode    = md;
      s_data  = pack(k);
      tmo = 0;
      while (!s_ready && tmo < 200) begin
        @(negedge clk156);
        tmo++;
      end
      if (tmo >= 200) check("s_ready_timeout", 0, 1);
      if (k == nw - 1) last_acc_cyc = cyc;
      @(posedge clk156);
    end
    @(negedge clk156);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_res_q.size() != 0 || exp_word_q.size() != 0 || m_valid) && t < 300) begin
      @(negedge clk156);
      t++;
    end
    if (t >= 300) check("drain_timeout", 0, 1);
  endtask

  task automatic reverify_capture(input string tag);
    for (int k = 0; k < hdr_n / LANES; k++)
      for (int j = 0; j < LANES; j++) hdr[k*LANES+j] = cap_words[k][W-1-16*j -: 16];
    send_hdr(1'b0);
    wait_drain();
    check(tag, last_ok, 1);
  endtask

  always @(negedge clk156) begin
    if (!sys_rst) begin
      if (m_valid) check("s_ready_in_emit", s_ready, 0);
      if (res_valid) begin
        if (exp_res_q.size() == 0) check("unexpected_res", 1, 0);
        else begin
          mr = exp_res_q.pop_front();
          check("res_csum", res_csum, mr.csum);
          check("res_ok", res_ok, mr.ok);
          check("res_ihl_err", res_ihl_err, mr.err);
          check("res_latency", cyc - last_acc_cyc, 3);
          check("m_sof_with_res", m_valid & m_sof, 1);
        end
        last_csum = res_csum;
        last_ok   = res_ok;
        last_err  = res_ihl_err;
      end
      if (m_valid && m_ready) begin
        if (exp_word_q.size() == 0) check("unexpected_word", 1, 0);
        else begin
          mw = exp_word_q.pop_front();
          check("m_data", m_data, mw.data);
          check("m_sof", m_sof, mw.sof);
          check("m_eof", m_eof, mw.eof);
          if (cap_n < 16) begin
            cap_words[cap_n] = m_data;
            cap_n++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk156);
    check("rst_m_valid", m_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_res_csum", res_csum, 0);
    check("rst_s_ready", s_ready, 1);
    sys_rst = 1'b0;
    repeat (2) @(negedge clk156);

    load12(T1);
    send_hdr(1'b0);
    wait_drain();
    check("t1_csum", last_csum, 16'h0000);
    check("t1_ok", last_ok, 1);

    load12(T1);
    hdr[5] = 16'h0000;
    send_hdr(1'b1);
    wait_drain();
    check("t2_csum", last_csum, 16'hb861);

    load12(T1);
    @(negedge clk156);
    s_valid = 1'b1; s_sof = 1'b1; mode = 1'b0; s_data = pack(0);
    @(posedge clk156);
    @(negedge clk156);
    s_valid = 1'b0; s_sof = 1'b0;
    sys_rst = 1'b1;
    #1;
    check("midrst_res_csum", res_csum, 0);
    check("midrst_res_ok", res_ok, 0);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 1);
    repeat (2) @(negedge clk156);
    sys_rst = 1'b0;
    repeat (6) @(negedge clk156);
    check("post_rst_quiet", m_valid | res_valid, 0);
    send_hdr(1'b0);
    wait_drain();
    check("post_rst_ok", last_ok, 1);

    load12(T3);
    send_hdr(1'b1);
    wait_drain();
    reverify_capture("ihl6_reverify_ok");

    load12(T1);
    hdr[0] = 16'h4300;
    send_hdr(1'b1);
    wait_drain();
    check("ihl3_err", last_err, 1);
    check("ihl3_ok", last_ok, 0);

    load12(T1);
    hdr[5] = 16'hb862;
    send_hdr(1'b0);
    wait_drain();
    check("badsum_ok", last_ok, 0);

    load12(T1);
    m_ready = 1'b1;
    send_hdr(1'b0);
    begin
      int t;
      t = 0;
      while (!m_valid && t < 20) begin
        @(negedge clk156);
        t++;
      end
      if (t >= 20) check("stall_wait_timeout", 0, 1);
    end
    @(posedge clk156); #1 m_ready = 1'b0;
    @(negedge clk156); d1 = m_data;
    @(posedge clk156); #1;
    @(negedge clk156); check("stall_data_hold1", m_data, d1);
    @(posedge clk156); #1 m_ready = 1'b1;
    @(negedge clk156); check("stall_data_hold2", m_data, d1);
    wait_drain();
    @(negedge clk156);
    check("stall_back_idle", s_ready & ~m_valid, 1);

    @(negedge clk156);
    s_valid = 1'b1; s_sof = 1'b0; s_data = {LANES{16'h4500}};
    @(posedge clk156);
    @(negedge clk156);
    load12(T1);
    s_sof = 1'b1; mode = 1'b0; s_data = pack(0);
    @(posedge clk156);
    hdr[5] = 16'h0000;
    send_hdr(1'b1);
    wait_drain();
    check("abort_restart_csum", last_csum, 16'hb861);

    hdr[0] = 16'h4F00;
    for (int i = 1; i < 32; i++) hdr[i] = 16'($urandom);
    hdr_n = 32;
    send_hdr(1'b1);
    wait_drain();
    reverify_capture("ihl15_reverify_ok");

    check("queues_empty", exp_res_q.size() + exp_word_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
